// File: rtl/flash_pkg.sv
// flash_pkg
//   Shared types and helpers for the flash prefetch reader.
//   flash_rd_state_t : reader control states (IDLE, RUN, DRAIN)
//   cnt_w(depth)     : bit width of a counter that must hold 0..depth inclusive
package flash_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } flash_rd_state_t;

    // A counter that reaches "depth" itself needs one value more than clog2(depth).
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/flash_prefetch_fifo.sv
// flash_prefetch_fifo
//   Register-array FIFO that buffers flash words ahead of the sample path.
//   Ports:
//     sample_clk, reset : clock, synchronous active-high reset
//     flush             : empty the FIFO (pointers and count to zero)
//     push, push_data   : write one word at the tail
//     pop               : drop the head word (ignored when empty)
//     head              : word at the head of the FIFO
//     cnt               : number of words held (0..DEPTH)
//     empty             : cnt == 0
//   Parameters: DATA_W word width, DEPTH entries (power of two, >= 2).
module flash_prefetch_fifo
    import flash_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                      sample_clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      push,
    input  logic [DATA_W-1:0]         push_data,
    input  logic                      pop,
    output logic [DATA_W-1:0]         head,
    output logic [cnt_w(DEPTH)-1:0]   cnt,
    output logic                      empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign head  = mem_q[rd_ptr_q];
    assign cnt   = cnt_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;

        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end

        // Storage contents are left alone on flush; only the bookkeeping resets.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge sample_clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // The parent's credit scheme never lets a response land on a full FIFO.
    a_no_overflow: assert property (@(posedge sample_clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/flash_prefetch_reader.sv
// flash_prefetch_reader
//   Avalon-MM flash read master that loops over an address window (forward or
//   reverse) and streams the words into a prefetch FIFO for the sample path.
//   Several reads may be outstanding; issue is gated by credits so that
//   buffered + outstanding words never exceed the FIFO depth.
//   Ports:
//     sample_clk, reset            : clock, synchronous active-high reset
//     start, stop, dir             : control pulses and direction (0 fwd, 1 rev)
//     start_addr, end_addr         : inclusive window bounds, sampled with start
//     flash_mem_*                  : Avalon-MM read master
//     data, data_valid, data_ready : consumer valid/ready stream
//     busy                         : reader not idle
//     underrun                     : registered pulse, consumer ready on empty FIFO
//     underrun_cnt                 : saturating underrun count
//                                    (only with FLASH_READER_UNDERRUN_CNT_EN)
//   Optional feature macro: FLASH_READER_UNDERRUN_CNT_EN
module flash_prefetch_reader
    import flash_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 23,
    parameter int DEPTH    = 8,
    parameter int MAX_PEND = 4
) (
    input  logic              sample_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              dir,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    input  logic              flash_mem_waitrequest,
    input  logic              flash_mem_readdatavalid,
    input  logic [DATA_W-1:0] flash_mem_readdata,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              busy,
`ifdef FLASH_READER_UNDERRUN_CNT_EN
    output logic [15:0]       underrun_cnt,
`endif
    output logic              underrun
);

    localparam int FCNT_W = cnt_w(DEPTH);
    localparam int PCNT_W = cnt_w(MAX_PEND);
    localparam int SUM_W  = FCNT_W + 1;

    flash_rd_state_t   state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] lo_q, lo_d;
    logic [ADDR_W-1:0] hi_q, hi_d;
    logic              dir_q, dir_d;
    logic [PCNT_W-1:0] pend_cnt_q, pend_cnt_d;
    logic              hold_q, hold_d;
    logic              underrun_q, underrun_d;

    logic              credit_ok;
    logic              issue;
    logic              accept;
    logic              rsp_dec;
    logic              push;
    logic              pop;
    logic              flush;
    logic [FCNT_W-1:0] fifo_cnt;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    flash_prefetch_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .sample_clk (sample_clk),
        .reset      (reset),
        .flush      (flush),
        .push       (push),
        .push_data  (flash_mem_readdata),
        .pop        (pop),
        .head       (fifo_head),
        .cnt        (fifo_cnt),
        .empty      (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        dir_d      = dir_q;
        pend_cnt_d = pend_cnt_q;
        flush      = 1'b0;

        // Every issued read owns a FIFO slot until its word is popped.
        credit_ok = (SUM_W'(fifo_cnt) + SUM_W'(pend_cnt_q)) < SUM_W'(DEPTH);
        issue     = (state_q == RUN) && credit_ok && (pend_cnt_q < PCNT_W'(MAX_PEND));

        // hold_q keeps a stalled request alive even after stop or credit loss.
        flash_mem_read = hold_q || issue;
        accept         = flash_mem_read && !flash_mem_waitrequest;
        hold_d         = flash_mem_read && flash_mem_waitrequest;

        // Strays (e.g. after reset) must not push the count below zero.
        rsp_dec = flash_mem_readdatavalid && (pend_cnt_q != '0);
        if (accept && !rsp_dec) begin
            pend_cnt_d = pend_cnt_q + 1'b1;
        end else if (!accept && rsp_dec) begin
            pend_cnt_d = pend_cnt_q - 1'b1;
        end

        push       = flash_mem_readdatavalid && (state_q == RUN);
        data_valid = (state_q == RUN) && !fifo_empty;
        pop        = data_valid && data_ready;
        underrun_d = (state_q == RUN) && data_ready && fifo_empty;

        if (accept) begin
            if (!dir_q) begin
                addr_d = (addr_q == hi_q) ? lo_q : addr_q + 1'b1;
            end else begin
                addr_d = (addr_q == lo_q) ? hi_q : addr_q - 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    lo_d    = start_addr;
                    hi_d    = end_addr;
                    dir_d   = dir;
                    addr_d  = dir ? end_addr : start_addr;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave only once nothing is outstanding and no request is on the bus.
                if ((pend_cnt_q == '0) && !flash_mem_read) begin
                    state_d = IDLE;
                    flush   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sample_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            dir_q      <= 1'b0;
            pend_cnt_q <= '0;
            hold_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            dir_q      <= dir_d;
            pend_cnt_q <= pend_cnt_d;
            hold_q     <= hold_d;
            underrun_q <= underrun_d;
        end
    end

    assign flash_mem_address = addr_q;
    assign data              = fifo_head;
    assign busy              = (state_q != IDLE);
    assign underrun          = underrun_q;

`ifdef FLASH_READER_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if ((state_q == IDLE) && start) begin
            ucnt_d = '0;
        end else if (underrun_q && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 1'b1;
        end
    end

    always_ff @(posedge sample_clk) begin
        if (reset) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_flash_prefetch_reader.sv
// tb_flash_prefetch_reader
//   Randomized bench: a fixed-latency flash responder with optional stalls
//   drives the reader; a transaction-level model (window arithmetic, word
//   queues, credit counts) predicts every output each cycle.
module tb_flash_prefetch_reader;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 23;
    localparam int DEPTH    = 8;
    localparam int MAX_PEND = 4;
    localparam int LAT      = 2;

    logic              sample_clk;
    logic              reset;
    logic              start;
    logic              stop;
    logic              dir;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic              flash_mem_read;
    logic [ADDR_W-1:0] flash_mem_address;
    logic              flash_mem_waitrequest;
    logic              flash_mem_readdatavalid;
    logic [DATA_W-1:0] flash_mem_readdata;
    logic [DATA_W-1:0] data;
    logic              data_valid;
    logic              data_ready;
    logic              busy;
    logic              underrun;
`ifdef FLASH_READER_UNDERRUN_CNT_EN
    logic [15:0]       underrun_cnt;
`endif

    flash_prefetch_reader #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .MAX_PEND (MAX_PEND)
    ) dut (
        .sample_clk              (sample_clk),
        .reset                   (reset),
        .start                   (start),
        .stop                    (stop),
        .dir                     (dir),
        .start_addr              (start_addr),
        .end_addr                (end_addr),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_waitrequest   (flash_mem_waitrequest),
        .flash_mem_readdatavalid (flash_mem_readdatavalid),
        .flash_mem_readdata      (flash_mem_readdata),
        .data                    (data),
        .data_valid              (data_valid),
        .data_ready              (data_ready),
        .busy                    (busy),
`ifdef FLASH_READER_UNDERRUN_CNT_EN
        .underrun_cnt            (underrun_cnt),
`endif
        .underrun                (underrun)
    );

    initial sample_clk = 1'b0;
    always #5 sample_clk = ~sample_clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'hA5A5_0000 ^ 32'(a);
    endfunction

    // flash responder
    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                due;
    } freq_t;
    freq_t fq[$];

    // reference model: 0 idle, 1 run, 2 drain
    int                m_state;
    int                m_out;
    int                m_buf;
    bit                m_held;
    bit                m_under;
    int                m_k;
    int                m_ucnt;
    logic [ADDR_W-1:0] m_lo, m_hi;
    bit                m_dir;
    logic [ADDR_W-1:0] m_aq[$];
    logic [DATA_W-1:0] m_dq[$];
    int                cyc;

    // drive plan for the next cycle
    bit                drv_reset, drv_start, drv_stop, drv_dir;
    logic [ADDR_W-1:0] drv_lo, drv_hi;
    int                wait_mode, ready_mode, stall_cnt;

    // values seen during the current cycle, consumed at the next edge
    bit                c_reset, c_start, c_stop, c_dir, c_ready, c_rvalid;
    bit                c_read_exp, c_acc_exp, c_pop_exp, c_wait;
    logic [ADDR_W-1:0] c_lo, c_hi;

    int                win_pops;
    bit                count_pops;

    function automatic logic [ADDR_W-1:0] addr_of(input int k);
        int n;
        int off;
        n   = int'(m_hi) - int'(m_lo) + 1;
        off = k % n;
        return m_dir ? ADDR_W'(int'(m_hi) - off) : ADDR_W'(int'(m_lo) + off);
    endfunction

    task automatic cycle();
        int                out0;
        bit                rd;
        bit                exp_read;
        bit                exp_valid;
        logic [ADDR_W-1:0] ra;
        @(posedge sample_clk);
        #1;
        cyc++;
        // ---- model update for the edge just taken
        if (c_reset) begin
            m_state = 0; m_out = 0; m_buf = 0; m_held = 0; m_under = 0;
            m_k = 0; m_ucnt = 0;
            m_aq.delete(); m_dq.delete();
        end else begin
            out0 = m_out;
            rd   = c_read_exp;
            if (m_under && m_ucnt < 65535) m_ucnt++;
            m_under = (m_state == 1) && c_ready && (m_buf == 0);
            if (c_pop_exp) begin
                m_buf--;
                void'(m_dq.pop_front());
            end
            if (c_rvalid && m_out > 0) begin
                ra = m_aq.pop_front();
                m_out--;
                if (m_state == 1) begin
                    m_dq.push_back(mem_word(ra));
                    m_buf++;
                end
            end
            if (c_acc_exp) begin
                m_aq.push_back(addr_of(m_k));
                m_k++;
                m_out++;
            end
            m_held = rd && c_wait;
            case (m_state)
                0: if (c_start) begin
                    m_state = 1; m_lo = c_lo; m_hi = c_hi; m_dir = c_dir;
                    m_k = 0; m_ucnt = 0;
                end
                1: if (c_stop) m_state = 2;
                default: if (out0 == 0 && !rd) begin
                    m_state = 0; m_buf = 0; m_dq.delete();
                end
            endcase
        end
        // ---- drive this cycle's inputs
        reset      = drv_reset;
        start      = drv_start;
        stop       = drv_stop;
        dir        = drv_dir;
        start_addr = drv_lo;
        end_addr   = drv_hi;
        case (wait_mode)
            1: flash_mem_waitrequest = ($urandom_range(0, 9) < 3);
            2: begin
                flash_mem_waitrequest = (m_k == 1) && (stall_cnt < 3);
                if (flash_mem_waitrequest) stall_cnt++;
            end
            default: flash_mem_waitrequest = 1'b0;
        endcase
        case (ready_mode)
            1: data_ready = $urandom_range(0, 1) == 1;
            2: data_ready = 1'b0;
            default: data_ready = 1'b1;
        endcase
        if (fq.size() > 0 && fq[0].due <= cyc) begin
            flash_mem_readdatavalid = 1'b1;
            flash_mem_readdata      = mem_word(fq[0].addr);
            void'(fq.pop_front());
        end else begin
            flash_mem_readdatavalid = 1'b0;
            flash_mem_readdata      = $urandom;
        end
        #1;
        // ---- compare this cycle's outputs
        exp_read  = m_held || (m_state == 1 && m_out < MAX_PEND && m_out + m_buf < DEPTH);
        exp_valid = (m_state == 1) && (m_buf > 0);
        chk("read", flash_mem_read, exp_read);
        if (exp_read) chk("addr", flash_mem_address, addr_of(m_k));
        chk("valid", data_valid, exp_valid);
        if (exp_valid) chk("data", data, m_dq[0]);
        chk("busy", busy, m_state != 0);
        chk("underrun", underrun, m_under);
`ifdef FLASH_READER_UNDERRUN_CNT_EN
        chk("ucnt", underrun_cnt, m_ucnt);
`endif
        if (flash_mem_read && !flash_mem_waitrequest) fq.push_back('{flash_mem_address, cyc + LAT});
        if (count_pops && data_valid && data_ready) win_pops++;
        c_reset    = reset;
        c_start    = start;
        c_stop     = stop;
        c_dir      = dir;
        c_lo       = start_addr;
        c_hi       = end_addr;
        c_ready    = data_ready;
        c_rvalid   = flash_mem_readdatavalid;
        c_wait     = flash_mem_waitrequest;
        c_read_exp = exp_read;
        c_acc_exp  = exp_read && !flash_mem_waitrequest;
        c_pop_exp  = exp_valid && data_ready;
    endtask

    task automatic drain_wait();
        int i;
        i = 0;
        while (busy && i < 100) begin
            cycle();
            i++;
        end
        chk("drain_done", busy, 1'b0);
        repeat (3) cycle();
    endtask

    task automatic session(input logic [ADDR_W-1:0] lo, input logic [ADDR_W-1:0] hi,
                           input bit d, input int run_cyc, input int wm, input int rm,
                           input bit both);
        drv_lo = lo; drv_hi = hi; drv_dir = d;
        wait_mode = wm; ready_mode = rm; stall_cnt = 0;
        // a stop in IDLE must be ignored
        drv_stop = 1'b1; cycle(); drv_stop = 1'b0;
        drv_start = 1'b1; drv_stop = both; cycle();
        drv_start = 1'b0; drv_stop = 1'b0;
        win_pops = 0;
        for (int i = 0; i < run_cyc; i++) begin
            drv_start  = (i == run_cyc / 2);  // start in RUN is ignored
            count_pops = (i >= 10);
            cycle();
        end
        drv_start = 1'b0; count_pops = 1'b0;
        drv_stop = 1'b1; cycle(); drv_stop = 1'b0;
        drain_wait();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0;
        start_addr = '0; end_addr = '0;
        flash_mem_waitrequest = 1'b0; flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata = '0; data_ready = 1'b0;
        c_reset = 1'b1; drv_reset = 1'b1;
        drv_start = 0; drv_stop = 0; drv_dir = 0; drv_lo = '0; drv_hi = '0;
        wait_mode = 0; ready_mode = 2; stall_cnt = 0; cyc = 0;
        win_pops = 0; count_pops = 0;
        m_lo = '0; m_hi = '0; m_dir = 0;
        repeat (2) @(posedge sample_clk);
        repeat (2) cycle();
        chk("rst_addr", flash_mem_address, '0);
        chk("rst_data", data, '0);
        drv_reset = 1'b0;
        cycle();

        session(23'h10, 23'h13, 1'b0, 40, 0, 0, 1'b0);
        session(23'h10, 23'h13, 1'b1, 40, 0, 0, 1'b0);
        session(23'h10, 23'h13, 1'b0, 30, 2, 0, 1'b0);
        session(23'h10, 23'h13, 1'b0, 30, 0, 2, 1'b0);
        session(23'h100, 23'h17F, 1'b0, 60, 0, 0, 1'b0);
        chk("thruput", win_pops, 50);
        session(23'h5, 23'h5, 1'b1, 25, 1, 1, 1'b0);
        session(23'h7FFFFE, 23'h7FFFFF, 1'b1, 25, 1, 1, 1'b1);
        for (int r = 0; r < 8; r++) begin
            logic [ADDR_W-1:0] lo;
            lo = ADDR_W'($urandom_range(0, 1000));
            session(lo, lo + ADDR_W'($urandom_range(0, 9)), $urandom_range(0, 1) == 1,
                    $urandom_range(10, 60), $urandom_range(0, 1), $urandom_range(0, 2), 1'b0);
        end

        // reset in the middle of streaming; responses still in flight arrive as strays
        drv_lo = 23'h40; drv_hi = 23'h47; drv_dir = 1'b0;
        wait_mode = 0; ready_mode = 1;
        drv_start = 1'b1; cycle(); drv_start = 1'b0;
        repeat (15) cycle();
        drv_reset = 1'b1; cycle(); drv_reset = 1'b0;
        cycle();
        chk("mid_rst_addr", flash_mem_address, '0);
        chk("mid_rst_data", data, '0);
        chk("mid_rst_busy", busy, 1'b0);
        repeat (8) cycle();
        session(23'h10, 23'h13, 1'b0, 30, 1, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
